// File: rtl/reg_bank_arbiter_pkg.sv
// Shared defaults and op encoding for the arbitrated register bank.
// Imported by the round-robin arbiter and the bank top level.
package reg_bank_arbiter_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_BW_DATA = 32;
    localparam int DEF_BW_ADDR = 5;
    localparam int DEF_BW_ID   = 2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: rotating priority pointer plus masked priority search.
// Grant is combinational; the pointer advances past the winner on every grant.
module rr_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int N = DEF_N_REQ
)
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] win_idx;
    logic [N-1:0]  upper_mask;
    logic [N-1:0]  masked_req;
    logic [N-1:0]  pick;
    logic          any_req;

    // Requests at or above the pointer take priority; if none, fall back to the full set (wrap).
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (PW'(i) >= ptr);
        end
        masked_req = i_req & upper_mask;
        pick       = (|masked_req) ? masked_req : i_req;
        o_gnt      = pick & (~pick + N'(1));
        any_req    = |i_req;
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (o_gnt[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    assign ptr_next = any_req ? (win_idx + PW'(1)) : ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Flop-based register bank shared by N_REQ requesters through a round-robin arbiter.
// One access per cycle; reads return one cycle after accept, tagged with the requester ID.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int BW_DATA = DEF_BW_DATA,
    parameter int BW_ADDR = DEF_BW_ADDR,
    parameter int BW_ID   = DEF_BW_ID
)
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ-1:0]           i_wen,
    input  logic [N_REQ*BW_ADDR-1:0]   i_addr,
    input  logic [N_REQ*BW_DATA-1:0]   i_wdata,
    output logic [N_REQ-1:0]           o_gnt,
    output logic                       o_rvalid,
    output logic [BW_ID-1:0]           o_rid,
    output logic [BW_DATA-1:0]         o_rdata
);

    localparam int DEPTH = 1 << BW_ADDR;

    logic [N_REQ-1:0]   gnt;
    logic               gnt_any;
    logic [BW_ID-1:0]   gnt_id;
    logic               sel_wen;
    logic [BW_ADDR-1:0] sel_addr;
    logic [BW_DATA-1:0] sel_wdata;
    logic               rd_accept;
    logic               wr_accept;

    logic [BW_DATA-1:0] bank [DEPTH];

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_req),
        .o_gnt (gnt)
    );

    assign o_gnt   = gnt;
    assign gnt_any = |gnt;

    // Grant is one-hot, so OR-ing the selected lanes is a plain mux.
    always_comb begin
        gnt_id    = '0;
        sel_wen   = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                gnt_id    = BW_ID'(k);
                sel_wen   = i_wen[k];
                sel_addr  = i_addr[k*BW_ADDR +: BW_ADDR];
                sel_wdata = i_wdata[k*BW_DATA +: BW_DATA];
            end
        end
    end

    assign rd_accept = gnt_any && (sel_wen == OP_RD);
    assign wr_accept = gnt_any && (sel_wen == OP_WR);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                bank[w] <= '0;
            end
        end else if (wr_accept) begin
            bank[sel_addr] <= sel_wdata;
        end
    end

    // rdata/rid hold their last read value so writes never disturb the response port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rvalid <= 1'b0;
            o_rid    <= '0;
            o_rdata  <= '0;
        end else begin
            o_rvalid <= rd_accept;
            if (rd_accept) begin
                o_rid   <= gnt_id;
                o_rdata <= bank[sel_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter with the default 4x32-word configuration.
// Inputs change between edges; grant is checked before each rising edge, responses just after.
module tb_reg_bank_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    i_req;
    logic [3:0]    i_wen;
    logic [19:0]   i_addr;
    logic [127:0]  i_wdata;
    logic [3:0]    o_gnt;
    logic          o_rvalid;
    logic [1:0]    o_rid;
    logic [31:0]   o_rdata;

    int checks;
    int failures;

    logic [3:0] rr_exp [8];
    logic [3:0] wrap_exp [3];
    logic [1:0] wrap_id [3];

    reg_bank_arbiter #(
        .N_REQ   (4),
        .BW_DATA (32),
        .BW_ADDR (5),
        .BW_ID   (2)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_req    (i_req),
        .i_wen    (i_wen),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .o_gnt    (o_gnt),
        .o_rvalid (o_rvalid),
        .o_rid    (o_rid),
        .o_rdata  (o_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic set_port(input int k, input logic wen, input logic [4:0] addr, input logic [31:0] data);
        i_wen[k]              = wen;
        i_addr[k*5 +: 5]      = addr;
        i_wdata[k*32 +: 32]   = data;
    endtask

    task automatic apply_stimulus(input logic [3:0] req);
        @(negedge clk);
        i_req = req;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_resp(input string tag, input logic valid, input logic [1:0] id, input logic [31:0] data);
        check_output({tag, "_rvalid"}, 32'(o_rvalid), 32'(valid));
        check_output({tag, "_rid"},    32'(o_rid),    32'(id));
        check_output({tag, "_rdata"},  o_rdata,       data);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        wrap_exp = '{4'b0010, 4'b1000, 4'b0010};
        wrap_id  = '{2'd1, 2'd3, 2'd1};

        rst     = 1'b1;
        i_req   = '0;
        i_wen   = '0;
        i_addr  = '0;
        i_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_resp("reset", 1'b0, 2'd0, 32'h0);
        check_output("reset_gnt", 32'(o_gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Fairness: all four read address 0 (cleared) for 8 cycles
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(4'b1111);
            check_output("rr_gnt", 32'(o_gnt), 32'(rr_exp[i]));
            clock_edge();
            check_resp("rr", 1'b1, 2'(i % 4), 32'h0);
        end

        // Wrap and skip with ptr back at 0
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b1010);
            check_output("wrap_gnt", 32'(o_gnt), 32'(wrap_exp[i]));
            clock_edge();
            check_resp("wrap", 1'b1, wrap_id[i], 32'h0);
        end

        // Single write then read by requester 0 (ptr=2 on entry)
        set_port(0, 1'b1, 5'd5, 32'hDEADBEEF);
        apply_stimulus(4'b0001);
        check_output("wr5_gnt", 32'(o_gnt), 32'h1);
        clock_edge();
        check_output("wr5_no_rvalid", 32'(o_rvalid), 32'h0);
        check_output("wr5_rdata_held", o_rdata, 32'h0);
        set_port(0, 1'b0, 5'd5, 32'h0);
        apply_stimulus(4'b0001);
        check_output("rd5_gnt", 32'(o_gnt), 32'h1);
        clock_edge();
        check_resp("rd5", 1'b1, 2'd0, 32'hDEADBEEF);

        // Requester 1 writes addr 1 = 0xA (ptr=1 -> 2)
        set_port(1, 1'b1, 5'd1, 32'h0000000A);
        apply_stimulus(4'b0010);
        check_output("wr1_gnt", 32'(o_gnt), 32'h2);
        clock_edge();
        check_output("wr1_no_rvalid", 32'(o_rvalid), 32'h0);
        check_output("wr1_rdata_held", o_rdata, 32'hDEADBEEF);

        // Read-after-write: req2 writes addr 31 while req1 waits to read it
        set_port(1, 1'b0, 5'd31, 32'h0);
        set_port(2, 1'b1, 5'd31, 32'h12345678);
        apply_stimulus(4'b0110);
        check_output("raw_wr_gnt", 32'(o_gnt), 32'h4);
        clock_edge();
        check_output("raw_wr_no_rvalid", 32'(o_rvalid), 32'h0);
        apply_stimulus(4'b0010);
        check_output("raw_rd_gnt", 32'(o_gnt), 32'h2);
        clock_edge();
        check_resp("raw", 1'b1, 2'd1, 32'h12345678);

        // Requester 3 writes addr 2 = 0xB (ptr=2 -> 0)
        set_port(3, 1'b1, 5'd2, 32'h0000000B);
        apply_stimulus(4'b1000);
        check_output("wr2_gnt", 32'(o_gnt), 32'h8);
        clock_edge();

        // Back-to-back reads from req0 then req3
        set_port(0, 1'b0, 5'd1, 32'h0);
        set_port(3, 1'b0, 5'd2, 32'h0);
        apply_stimulus(4'b1001);
        check_output("b2b0_gnt", 32'(o_gnt), 32'h1);
        clock_edge();
        check_resp("b2b0", 1'b1, 2'd0, 32'h0000000A);
        apply_stimulus(4'b1000);
        check_output("b2b1_gnt", 32'(o_gnt), 32'h8);
        clock_edge();
        check_resp("b2b1", 1'b1, 2'd3, 32'h0000000B);
        apply_stimulus(4'b0000);
        check_output("idle_gnt", 32'(o_gnt), 32'h0);
        clock_edge();
        check_output("idle_rvalid", 32'(o_rvalid), 32'h0);

        // Grant req1 (ptr -> 2), idle holds ptr, then all four request
        set_port(1, 1'b0, 5'd31, 32'h0);
        apply_stimulus(4'b0010);
        clock_edge();
        check_resp("rd31", 1'b1, 2'd1, 32'h12345678);
        apply_stimulus(4'b0000);
        clock_edge();
        check_output("hold_rvalid", 32'(o_rvalid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_port(k, 1'b0, 5'd5, 32'h0);
        end
        apply_stimulus(4'b1111);
        check_output("hold_gnt", 32'(o_gnt), 32'h4);
        clock_edge();
        check_resp("hold_rd", 1'b1, 2'd2, 32'hDEADBEEF);

        // Reset mid-cycle with a response in flight and all requesting
        #2;
        rst = 1'b1;
        #1;
        check_resp("midrst", 1'b0, 2'd0, 32'h0);
        check_output("midrst_gnt", 32'(o_gnt), 32'h1);
        i_req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;

        // Bank cleared: previously written addresses read back as 0
        apply_stimulus(4'b0001);
        check_output("post_rst_gnt", 32'(o_gnt), 32'h1);
        clock_edge();
        check_resp("post_rst_rd5", 1'b1, 2'd0, 32'h0);
        set_port(0, 1'b0, 5'd31, 32'h0);
        apply_stimulus(4'b0001);
        clock_edge();
        check_resp("post_rst_rd31", 1'b1, 2'd0, 32'h0);
        apply_stimulus(4'b0000);
        clock_edge();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
